// File: rtl/receive.sv
// Serial frame receiver: start bit, 256 data bits MSB first, even parity, stop bit.
// Oversamples the line at BIT_CYCLES clocks per bit and emits one-cycle status pulses.
module receive #(
  parameter int BIT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ant_in,
  output logic [255:0] key_out,
  output logic         key_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [7:0]     bit_q, bit_d;
  logic [255:0]   shift_q, shift_d;
  logic           par_q, par_d;
  logic [255:0]   key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           parity_err_q, parity_err_d;
  logic           frame_err_q, frame_err_d;
  logic           busy_q, busy_d;
  logic           sync1_q, sync2_q;
  logic           rx_s;
  logic           bit_tick;

  // Idle level is 1, so the synchronizer resets high to avoid a phantom start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ant_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s     = sync2_q;
  assign bit_tick = (cyc_q == BIT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    key_d        = key_q;
    key_valid_d  = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        par_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          cyc_d   = '0;
          shift_d = {shift_q[254:0], rx_s};
          par_d   = par_q ^ rx_s;
          if (bit_q == 8'd255) state_d = PARITY;
          else                 bit_d   = bit_q + 8'd1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cyc_d   = '0;
          par_d   = par_q ^ rx_s;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          cyc_d = '0;
          // A low stop bit outranks a parity mismatch; a held-low line must not retrigger.
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end else if (par_q) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
          end else begin
            key_d       = shift_q;
            key_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        cyc_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      par_q        <= 1'b0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      par_q        <= par_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // NOTE: the shift register is pure datapath, fully refilled before it is ever published, so it has no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign key_out    = key_q;
  assign key_valid  = key_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_receive.sv
// Directed bench for receive: good, back-to-back, parity, framing, glitch and mid-frame reset cases.
module tb_receive;

  localparam int BC = 16;
  localparam int STOP_LAT = 2 + BC / 2 + 258 * BC;   // edge T to status pulse

  logic         clk;
  logic         reset;
  logic         ant_in;
  logic [255:0] key_out;
  logic         key_valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;

  int cyc      = 0;
  int kv_cnt   = 0, pe_cnt = 0, fe_cnt = 0;
  int kv_cyc   = 0, pe_cyc = 0, fe_cyc = 0;
  int busy_cnt = 0;
  int viol     = 0;
  logic prev_any = 1'b0;

  receive #(.BIT_CYCLES(BC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ant_in    (ant_in),
    .key_out   (key_out),
    .key_valid (key_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges and logs status pulses 1 time unit after each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (key_valid)  begin kv_cnt++; kv_cyc = cyc; end
    if (parity_err) begin pe_cnt++; pe_cyc = cyc; end
    if (frame_err)  begin fe_cnt++; fe_cyc = cyc; end
    if (busy) busy_cnt++;
    if ((int'(key_valid) + int'(parity_err) + int'(frame_err)) > 1) viol++;
    if (prev_any && (key_valid || parity_err || frame_err)) viol++;
    prev_any = key_valid || parity_err || frame_err;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    ant_in = b;
    repeat (BC) @(negedge clk);
  endtask

  // Called at a falling edge; t0 is the number of the rising edge that first captures the start bit.
  task automatic send_frame(input logic [255:0] d, input logic par_flip,
                            input logic stop, output int t0);
    ant_in = 1'b0;
    t0 = cyc + 1;
    repeat (BC) @(negedge clk);
    for (int i = 255; i >= 0; i--) drive_bit(d[i]);
    drive_bit((^d) ^ par_flip);
    drive_bit(stop);
  endtask

  logic [255:0] p0, p1;
  int t0, t1, first_kv, b0;

  initial begin
    p0 = {4{64'hABCDEF0123456789}};
    p1 = {8{32'h5A3C96E1}};
    ant_in = 1'b1;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_key",   key_out,    256'h0);
    check("rst_kv",    key_valid,  1'b0);
    check("rst_pe",    parity_err, 1'b0);
    check("rst_fe",    frame_err,  1'b0);
    check("rst_busy",  busy,       1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Single good frame with exact pulse latency.
    send_frame(p0, 1'b0, 1'b1, t0);
    check("good_cnt",   kv_cnt,       1);
    check("good_time",  kv_cyc - t0,  STOP_LAT);
    check("good_key",   key_out,      p0);
    check("good_noerr", pe_cnt + fe_cnt, 0);
    repeat (20) @(negedge clk);

    // Back-to-back frames with a single-bit stop.
    send_frame(256'h0, 1'b0, 1'b1, t0);
    first_kv = kv_cyc;
    check("b2b_key0",  key_out, 256'h0);
    send_frame(256'h1, 1'b0, 1'b1, t1);
    check("b2b_cnt",   kv_cnt, 3);
    check("b2b_gap",   kv_cyc - first_kv, 259 * BC);
    check("b2b_key1",  key_out, 256'h1);
    repeat (20) @(negedge clk);

    // Parity bit flipped: discard and hold key_out.
    send_frame(p0, 1'b1, 1'b1, t0);
    check("par_cnt",   pe_cnt, 1);
    check("par_time",  pe_cyc - t0, STOP_LAT);
    check("par_nokv",  kv_cnt, 3);
    check("par_hold",  key_out, 256'h1);
    repeat (20) @(negedge clk);

    // Low stop bit then a held-low line: one frame_err, no retrigger.
    send_frame(p0, 1'b0, 1'b0, t0);
    repeat (100) @(negedge clk);
    check("fe_cnt",    fe_cnt, 1);
    check("fe_time",   fe_cyc - t0, STOP_LAT);
    check("fe_busy",   busy, 1'b1);
    ant_in = 1'b1;
    repeat (40) @(negedge clk);
    check("fe_idle",   busy, 1'b0);
    check("fe_once",   fe_cnt, 1);
    check("fe_others", kv_cnt + pe_cnt, 4);
    check("fe_hold",   key_out, 256'h1);

    // Five-cycle glitch is a false start.
    b0 = busy_cnt;
    ant_in = 1'b0;
    repeat (5) @(negedge clk);
    ant_in = 1'b1;
    repeat (30) @(negedge clk);
    check("gl_busy",   busy_cnt - b0, 8);
    check("gl_pulses", kv_cnt + pe_cnt + fe_cnt, 5);
    check("gl_idle",   busy, 1'b0);

    // Reset in the middle of the data bits, then a clean frame.
    ant_in = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 100; i++) drive_bit(p1[255 - i]);
    reset  = 1'b1;
    ant_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mr_key",    key_out, 256'h0);
    check("mr_busy",   busy, 1'b0);
    check("mr_flags",  {key_valid, parity_err, frame_err}, 3'b000);
    repeat (20) @(negedge clk);
    check("mr_nopulse", kv_cnt + pe_cnt + fe_cnt, 5);
    send_frame(p1, 1'b0, 1'b1, t0);
    check("mr_cnt",    kv_cnt, 4);
    check("mr_time",   kv_cyc - t0, STOP_LAT);
    check("mr_key2",   key_out, p1);
    repeat (10) @(negedge clk);

    check("pulse_excl", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
